// File: rtl/rate_divider_prog.sv
// rtl/rate_divider_prog.sv - programmable rate divider with periodic, square and one-shot modes
module rate_divider_prog #(
  parameter int WIDTH       = 28,
  parameter int DEFAULT_DIV = 25_000_000
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic             EN,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] DIV_IN,
  input  logic [1:0]       MODE_IN,
  output logic             TICK,
  output logic             WAVE,
  output logic             DONE,
  output logic [WIDTH-1:0] COUNT
);

  localparam logic [1:0] MODE_SQUARE  = 2'b01;
  localparam logic [1:0] MODE_ONESHOT = 2'b10;

  logic [WIDTH-1:0] period_q;
  logic [1:0]       mode_q;
  logic [WIDTH-1:0] count_q;
  logic             tick_q;
  logic             wave_q;
  logic             done_q;

  logic             terminal;
  logic             halted;
  logic [WIDTH-1:0] load_period;

  // Terminal count detection; period_q is never zero so period_q-1 cannot underflow.
  always_comb begin
    terminal    = (count_q == period_q - WIDTH'(1));
    halted      = done_q;
    load_period = (DIV_IN == '0) ? WIDTH'(1) : DIV_IN;
  end

  // Counter, mode/period latches and registered outputs; priority reset > load > count > hold.
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      period_q <= WIDTH'(DEFAULT_DIV);
      mode_q   <= 2'b00;
      count_q  <= '0;
      tick_q   <= 1'b0;
      wave_q   <= 1'b0;
      done_q   <= 1'b0;
    end else if (LOAD) begin
      period_q <= load_period;
      mode_q   <= MODE_IN;
      count_q  <= '0;
      tick_q   <= 1'b0;
      wave_q   <= 1'b0;
      done_q   <= 1'b0;
    end else if (EN && !halted) begin
      if (terminal) begin
        count_q <= '0;
        tick_q  <= 1'b1;
        if (mode_q == MODE_SQUARE) begin
          wave_q <= ~wave_q;
        end
        if (mode_q == MODE_ONESHOT) begin
          done_q <= 1'b1;
        end
      end else begin
        count_q <= count_q + WIDTH'(1);
        tick_q  <= 1'b0;
      end
    end else begin
      // Stalled or halted one-shot: hold state, never stretch a pulse.
      tick_q <= 1'b0;
    end
  end

  assign TICK  = tick_q;
  assign WAVE  = wave_q;
  assign DONE  = done_q;
  assign COUNT = count_q;

endmodule

// File: tb/tb_rate_divider_prog.sv
// tb/tb_rate_divider_prog.sv - randomized self-checking bench for rate_divider_prog
module tb_rate_divider_prog;

  localparam int WIDTH = 8;
  localparam int DDIV  = 10;

  logic             clk;
  logic             resetn;
  logic             en;
  logic             load;
  logic [WIDTH-1:0] div_in;
  logic [1:0]       mode_in;
  logic             tick;
  logic             wave;
  logic             done;
  logic [WIDTH-1:0] count;

  int vectors;
  int miscompares;

  // Reference state: period, mode, and number of counted enable edges since load/reset.
  longint m_period;
  int     m_mode;
  longint m_n;
  int     m_tick;

  rate_divider_prog #(.WIDTH(WIDTH), .DEFAULT_DIV(DDIV)) dut (
    .CLK    (clk),
    .RESETN (resetn),
    .EN     (en),
    .LOAD   (load),
    .DIV_IN (div_in),
    .MODE_IN(mode_in),
    .TICK   (tick),
    .WAVE   (wave),
    .DONE   (done),
    .COUNT  (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got, input longint exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  function automatic bit m_oneshot_done();
    return (m_mode == 2) && (m_n >= m_period);
  endfunction

  // Advance the reference by one clock edge given the inputs applied to it.
  task automatic model_edge(input bit r, input bit l, input bit e, input int d, input int md);
    if (!r) begin
      m_period = DDIV; m_mode = 0; m_n = 0; m_tick = 0;
    end else if (l) begin
      m_period = (d == 0) ? 1 : d; m_mode = md; m_n = 0; m_tick = 0;
    end else if (e && !m_oneshot_done()) begin
      m_n++;
      m_tick = (m_n % m_period == 0) ? 1 : 0;
    end else begin
      m_tick = 0;
    end
  endtask

  // Drive one cycle of stimulus, then compare all outputs against the reference.
  task automatic step(input bit r, input bit l, input bit e, input int d, input int md);
    longint exp_count;
    longint exp_wave;
    @(negedge clk);
    resetn = r; load = l; en = e; div_in = WIDTH'(d); mode_in = 2'(md);
    model_edge(r, l, e, d, md);
    exp_count = m_oneshot_done() ? 0 : (m_n % m_period);
    exp_wave  = (m_mode == 1) ? ((m_n / m_period) % 2) : 0;
    @(posedge clk);
    #1;
    check("tick",  longint'(tick),  m_tick);
    check("count", longint'(count), exp_count);
    check("wave",  longint'(wave),  exp_wave);
    check("done",  longint'(done),  longint'(m_oneshot_done()));
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    m_period = DDIV; m_mode = 0; m_n = 0; m_tick = 0;
    resetn = 1'b0; load = 1'b0; en = 1'b0; div_in = '0; mode_in = '0;

    // Reset, then default period with EN steady.
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    for (int i = 0; i < 35; i++) step(1, 0, 1, 0, 0);

    // Square mode, period 4.
    step(1, 1, 1, 4, 1);
    for (int i = 0; i < 20; i++) step(1, 0, 1, 0, 0);

    // One-shot, period 3, then long idle with EN high.
    step(1, 1, 1, 3, 2);
    for (int i = 0; i < 25; i++) step(1, 0, 1, 0, 0);

    // Period 5 with EN alternating.
    step(1, 1, 0, 5, 0);
    for (int i = 0; i < 24; i++) step(1, 0, i % 2 == 0, 0, 0);

    // Period 0 and 1 both tick every cycle; square at period 1 toggles every cycle.
    step(1, 1, 1, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 0, 1, 0, 0);
    step(1, 1, 1, 1, 1);
    for (int i = 0; i < 5; i++) step(1, 0, 1, 0, 0);

    // Reset mid-pulse in square mode, period 6.
    step(1, 1, 1, 6, 1);
    for (int i = 0; i < 8; i++) step(1, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    step(1, 0, 1, 0, 0);

    // Random phase.
    for (int i = 0; i < 3000; i++) begin
      bit r, l, e;
      r = ($urandom_range(0, 199) != 0);
      l = ($urandom_range(0, 29) == 0);
      e = ($urandom_range(0, 3) != 0);
      step(r, l, e, int'($urandom_range(0, 12)), int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
